// File: rtl/uart_rx_ctrl.sv
// uart_rx_ctrl: host configuration scheduler, receive-timeout generator and
// sticky error/interrupt logic for the UART receiver.
module uart_rx_ctrl #(
  parameter int BAUD_PRESCALER = 12,
  parameter int PARITY         = 0,
  parameter int BYTE_SIZE      = 8,
  parameter int STOP_BITS      = 0,
  parameter int TIMEOUT_W      = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [26:0]          host_cfg_data,
  input  logic                 host_cfg_wr,
  output logic                 host_cfg_busy,
  output logic [26:0]          cfg_tdata,
  output logic                 cfg_tvalid,
  input  logic                 cfg_tready,
  output logic [26:0]          active_cfg,
  input  logic                 rx_tvalid,
  input  logic                 rx_tready,
  input  logic [31:0]          rx_data_count,
  input  logic [4:0]           rx_error,
  input  logic [TIMEOUT_W-1:0] timeout_bits,
  output logic [4:0]           err_status,
  input  logic [4:0]           err_clr,
  input  logic [4:0]           irq_mask,
  output logic                 irq
);

  // Must match the receiver's own power-on configuration.
  localparam logic [26:0] RESET_CFG = {2'b00, 1'b1, STOP_BITS[0], BYTE_SIZE[3:0],
                                       PARITY[2:0], BAUD_PRESCALER[15:0]};

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    ISSUE = 1'b1
  } state_t;

  state_t                 state_r;
  logic [15:0]            presc_r;
  logic [TIMEOUT_W-1:0]   bit_cnt_r;

  logic                   cfg_accept_s;
  logic [15:0]            presc_max_s;
  logic                   tick_s;
  logic                   timer_clr_s;
  logic [TIMEOUT_W-1:0]   last_bit_s;
  logic                   timeout_event_s;
  logic [4:0]             err_next_s;
  logic                   unused_s;

  // The receiver's own timeout flag is always 0; this block generates it instead.
  assign unused_s = rx_error[4];

  assign cfg_accept_s = (state_r == ISSUE) & cfg_tready;

  // A prescaler of 0 behaves like 1 so the tick never stalls.
  assign presc_max_s = (active_cfg[15:0] == 16'd0) ? 16'd0 : (active_cfg[15:0] - 16'd1);
  assign tick_s      = (presc_r >= presc_max_s);

  assign timer_clr_s = (rx_tvalid & rx_tready) |
                       (rx_data_count == 32'd0) |
                       ~active_cfg[24] |
                       (timeout_bits == {TIMEOUT_W{1'b0}}) |
                       cfg_accept_s;

  assign last_bit_s      = timeout_bits - {{(TIMEOUT_W-1){1'b0}}, 1'b1};
  // Fires only on the step into saturation, so a held counter never re-fires.
  assign timeout_event_s = ~timer_clr_s & tick_s & (bit_cnt_r < timeout_bits) &
                           (bit_cnt_r == last_bit_s);

  // Set has priority over clear.
  assign err_next_s = (err_status & ~err_clr) | {timeout_event_s, rx_error[3:0]};

  // Config handshake FSM: hold one write until the receiver takes it.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r       <= IDLE;
      cfg_tvalid    <= 1'b0;
      cfg_tdata     <= 27'd0;
      host_cfg_busy <= 1'b0;
      active_cfg    <= RESET_CFG;
    end else begin
      case (state_r)
        IDLE: begin
          if (host_cfg_wr) begin
            cfg_tdata     <= host_cfg_data;
            cfg_tvalid    <= 1'b1;
            host_cfg_busy <= 1'b1;
            state_r       <= ISSUE;
          end
        end
        ISSUE: begin
          if (cfg_tready) begin
            cfg_tvalid    <= 1'b0;
            host_cfg_busy <= 1'b0;
            active_cfg    <= cfg_tdata;
            state_r       <= IDLE;
          end
        end
        default: begin
          cfg_tvalid    <= 1'b0;
          host_cfg_busy <= 1'b0;
          state_r       <= IDLE;
        end
      endcase
    end
  end

  // Idle timer: bit-time prescaler plus saturating bit counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      presc_r   <= 16'd0;
      bit_cnt_r <= {TIMEOUT_W{1'b0}};
    end else if (timer_clr_s) begin
      presc_r   <= 16'd0;
      bit_cnt_r <= {TIMEOUT_W{1'b0}};
    end else begin
      presc_r <= tick_s ? 16'd0 : (presc_r + 16'd1);
      if (tick_s && (bit_cnt_r < timeout_bits)) begin
        bit_cnt_r <= bit_cnt_r + {{(TIMEOUT_W-1){1'b0}}, 1'b1};
      end
    end
  end

  // Sticky error bits and the registered interrupt derived from their next value.
  always_ff @(posedge clk) begin
    if (rst) begin
      err_status <= 5'd0;
      irq        <= 1'b0;
    end else begin
      err_status <= err_next_s;
      irq        <= |(err_next_s & irq_mask);
    end
  end

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Self-checking bench for uart_rx_ctrl: config handshake scoreboard,
// timeout timing, gating, sticky errors and interrupt.
module tb_uart_rx_ctrl;

  localparam int TW = 8;
  localparam logic [26:0] DEF_CFG = {2'b00, 1'b1, 1'b0, 4'd8, 3'd0, 16'd12};

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [26:0]   host_cfg_data = 27'd0;
  logic          host_cfg_wr = 1'b0;
  logic          host_cfg_busy;
  logic [26:0]   cfg_tdata;
  logic          cfg_tvalid;
  logic          cfg_tready = 1'b0;
  logic [26:0]   active_cfg;
  logic          rx_tvalid = 1'b0;
  logic          rx_tready = 1'b0;
  logic [31:0]   rx_data_count = 32'd0;
  logic [4:0]    rx_error = 5'd0;
  logic [TW-1:0] timeout_bits = '0;
  logic [4:0]    err_status;
  logic [4:0]    err_clr = 5'd0;
  logic [4:0]    irq_mask = 5'd0;
  logic          irq;

  int checks = 0;
  int errors = 0;
  logic [26:0] exp_cfg_q[$];
  logic [5:0]  exp_err_q[$];

  uart_rx_ctrl #(.BAUD_PRESCALER(12), .PARITY(0), .BYTE_SIZE(8), .STOP_BITS(0), .TIMEOUT_W(TW)) dut (
    .clk(clk), .rst(rst),
    .host_cfg_data(host_cfg_data), .host_cfg_wr(host_cfg_wr), .host_cfg_busy(host_cfg_busy),
    .cfg_tdata(cfg_tdata), .cfg_tvalid(cfg_tvalid), .cfg_tready(cfg_tready),
    .active_cfg(active_cfg),
    .rx_tvalid(rx_tvalid), .rx_tready(rx_tready), .rx_data_count(rx_data_count),
    .rx_error(rx_error), .timeout_bits(timeout_bits),
    .err_status(err_status), .err_clr(err_clr), .irq_mask(irq_mask), .irq(irq)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One-cycle host write; accepted writes go into the scoreboard.
  task automatic host_write(input logic [26:0] data, input bit expect_accept);
    host_cfg_data = data;
    host_cfg_wr   = 1'b1;
    if (expect_accept) exp_cfg_q.push_back(data);
    tick();
    host_cfg_wr = 1'b0;
  endtask

  // Raise tready and wait (bounded) for the handshake; compare against the scoreboard.
  task automatic wait_accept(input int budget);
    logic [26:0] exp;
    bit done;
    done = 1'b0;
    cfg_tready = 1'b1;
    for (int i = 0; i < budget && !done; i++) begin
      if (cfg_tvalid === 1'b1) begin
        checks++;
        if (exp_cfg_q.size() == 0) begin
          errors++;
          $display("FAIL accept_unexpected: got handshake with tdata %h, required no pending write", cfg_tdata);
          exp = cfg_tdata;
        end else begin
          exp = exp_cfg_q.pop_front();
          if (cfg_tdata !== exp) begin
            errors++;
            $display("FAIL accept_tdata: got %h required %h", cfg_tdata, exp);
          end
        end
        tick();
        checks++;
        if (active_cfg !== exp) begin
          errors++;
          $display("FAIL accept_active: got %h required %h", active_cfg, exp);
        end
        checks++;
        if (cfg_tvalid !== 1'b0 || host_cfg_busy !== 1'b0) begin
          errors++;
          $display("FAIL accept_release: got tvalid=%b busy=%b required 0 0", cfg_tvalid, host_cfg_busy);
        end
        done = 1'b1;
      end else begin
        tick();
      end
    end
    cfg_tready = 1'b0;
    if (!done) begin
      checks++;
      errors++;
      $display("FAIL accept_wait: got no cfg_tvalid within %0d cycles, required handshake", budget);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    checks++; if (cfg_tvalid !== 1'b0) begin errors++; $display("FAIL reset_tvalid: got %b required 0", cfg_tvalid); end
    checks++; if (host_cfg_busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b required 0", host_cfg_busy); end
    checks++; if (cfg_tdata !== 27'd0) begin errors++; $display("FAIL reset_tdata: got %h required 0", cfg_tdata); end
    checks++; if (active_cfg !== DEF_CFG) begin errors++; $display("FAIL reset_active: got %h required %h", active_cfg, DEF_CFG); end
    checks++; if (err_status !== 5'd0) begin errors++; $display("FAIL reset_err: got %b required 0", err_status); end
    checks++; if (irq !== 1'b0) begin errors++; $display("FAIL reset_irq: got %b required 0", irq); end
  endtask

  task automatic test_write_during_receive();
    logic [26:0] v;
    v = 27'h1C00064;
    cfg_tready = 1'b0;
    host_write(v, 1'b1);
    for (int i = 0; i < 40; i++) begin
      checks++;
      if (cfg_tvalid !== 1'b1 || cfg_tdata !== v || host_cfg_busy !== 1'b1) begin
        errors++;
        $display("FAIL hold_stable: cycle %0d got tvalid=%b tdata=%h busy=%b required 1 %h 1",
                 i, cfg_tvalid, cfg_tdata, host_cfg_busy, v);
      end
      tick();
    end
    wait_accept(4);
  endtask

  task automatic test_write_while_busy();
    logic [26:0] a;
    a = 27'h1400020;
    host_write(a, 1'b1);
    tick();
    host_write(27'h1000010, 1'b0);
    checks++;
    if (cfg_tdata !== a) begin errors++; $display("FAIL busy_overwrite: got %h required %h", cfg_tdata, a); end
    tick();
    wait_accept(4);
    checks++;
    if (exp_cfg_q.size() != 0) begin
      errors++;
      $display("FAIL busy_queue: got %0d pending required 0", exp_cfg_q.size());
    end
    tick();
    checks++;
    if (cfg_tvalid !== 1'b0 || active_cfg !== a) begin
      errors++;
      $display("FAIL busy_final: got tvalid=%b active=%h required 0 %h", cfg_tvalid, active_cfg, a);
    end
  endtask

  task automatic test_back_to_back();
    logic [26:0] exp;
    cfg_tready = 1'b1;
    host_cfg_data = 27'h1400030; host_cfg_wr = 1'b1; exp_cfg_q.push_back(27'h1400030);
    tick();
    checks++;
    if (cfg_tvalid !== 1'b1 || cfg_tdata !== exp_cfg_q[0]) begin
      errors++;
      $display("FAIL b2b_issue: got tvalid=%b tdata=%h required 1 %h", cfg_tvalid, cfg_tdata, exp_cfg_q[0]);
    end
    host_cfg_data = 27'h1400040;
    tick();
    exp = exp_cfg_q.pop_front();
    checks++;
    if (active_cfg !== exp || cfg_tvalid !== 1'b0 || host_cfg_busy !== 1'b0) begin
      errors++;
      $display("FAIL b2b_accept: got active=%h tvalid=%b busy=%b required %h 0 0",
               active_cfg, cfg_tvalid, host_cfg_busy, exp);
    end
    host_cfg_data = 27'h140000A; exp_cfg_q.push_back(27'h140000A);
    tick();
    host_cfg_wr = 1'b0;
    checks++;
    if (cfg_tvalid !== 1'b1 || cfg_tdata !== exp_cfg_q[0]) begin
      errors++;
      $display("FAIL b2b_second: got tvalid=%b tdata=%h required 1 %h", cfg_tvalid, cfg_tdata, exp_cfg_q[0]);
    end
    tick();
    exp = exp_cfg_q.pop_front();
    checks++;
    if (active_cfg !== exp || cfg_tvalid !== 1'b0) begin
      errors++;
      $display("FAIL b2b_final: got active=%h tvalid=%b required %h 0", active_cfg, cfg_tvalid, exp);
    end
    cfg_tready = 1'b0;
  endtask

  // Prescaler 10, 4 bit-times: flag appears 40 cycles after the last clear.
  task automatic test_timeout();
    rx_data_count = 32'd3;
    timeout_bits  = 8'd4;
    for (int n = 1; n <= 40; n++) begin
      tick();
      checks++;
      if (err_status[4] !== (n >= 40)) begin
        errors++;
        $display("FAIL timeout_time: cycle %0d got %b required %b", n, err_status[4], (n >= 40));
      end
    end
    err_clr = 5'b10000;
    tick();
    err_clr = 5'b00000;
    for (int n = 0; n < 100; n++) begin
      tick();
      checks++;
      if (err_status[4] !== 1'b0) begin
        errors++;
        $display("FAIL timeout_refire: cycle %0d got %b required 0", n, err_status[4]);
      end
    end
  endtask

  // A receive beat at cycle 35 restarts the count; next event lands at cycle 75.
  task automatic test_timeout_beat();
    rx_data_count = 32'd0;
    tick();
    rx_data_count = 32'd3;
    for (int n = 1; n <= 76; n++) begin
      tick();
      checks++;
      if (err_status[4] !== (n >= 75)) begin
        errors++;
        $display("FAIL timeout_beat: cycle %0d got %b required %b", n, err_status[4], (n >= 75));
      end
      if (n == 34) begin rx_tvalid = 1'b1; rx_tready = 1'b1; end
      else begin rx_tvalid = 1'b0; rx_tready = 1'b0; end
    end
    rx_data_count = 32'd0;
    err_clr = 5'b10000;
    tick();
    err_clr = 5'b00000;
  endtask

  task automatic test_timeout_gated();
    bit seen;
    for (int c = 0; c < 3; c++) begin
      if (c == 2) begin
        rx_data_count = 32'd0;
        timeout_bits  = 8'd0;
        host_write(27'h040000A, 1'b1);
        wait_accept(4);
      end
      rx_data_count = (c == 0) ? 32'd0 : 32'd3;
      timeout_bits  = (c == 1) ? 8'd0 : 8'd4;
      seen = 1'b0;
      for (int n = 0; n < 1000; n++) begin
        tick();
        if (err_status[4] !== 1'b0) seen = 1'b1;
      end
      checks++;
      if (seen) begin errors++; $display("FAIL timeout_gated: case %0d got timeout set, required never", c); end
    end
    rx_data_count = 32'd0;
    timeout_bits  = 8'd0;
  endtask

  task automatic test_errors_irq();
    logic [4:0] t_rx  [11];
    logic [4:0] t_clr [11];
    logic [4:0] t_msk [11];
    logic [5:0] model;
    logic [5:0] exp;
    logic [4:0] err_m;
    t_rx  = '{5'b00100, 5'b00000, 5'b00100, 5'b00000, 5'b00100, 5'b00000,
              5'b10000, 5'b01011, 5'b00000, 5'b00001, 5'b00000};
    t_clr = '{5'b00000, 5'b00000, 5'b00100, 5'b00100, 5'b00000, 5'b00000,
              5'b00000, 5'b00100, 5'b01011, 5'b00000, 5'b11111};
    t_msk = '{5'b00100, 5'b00100, 5'b00100, 5'b00100, 5'b00000, 5'b00000,
              5'b11111, 5'b01000, 5'b01000, 5'b00010, 5'b00000};
    err_m = 5'd0;
    for (int s = 0; s < 11; s++) begin
      rx_error = t_rx[s];
      err_clr  = t_clr[s];
      irq_mask = t_msk[s];
      err_m = (err_m & ~t_clr[s]) | {1'b0, t_rx[s][3:0]};
      model = {err_m, |(err_m & t_msk[s])};
      exp_err_q.push_back(model);
      tick();
      exp = exp_err_q.pop_front();
      checks++;
      if ({err_status, irq} !== exp) begin
        errors++;
        $display("FAIL err_irq: step %0d got err=%b irq=%b required err=%b irq=%b",
                 s, err_status, irq, exp[5:1], exp[0]);
      end
    end
    rx_error = 5'd0;
    err_clr  = 5'd0;
    irq_mask = 5'd0;
  endtask

  task automatic test_reset_mid_transaction();
    cfg_tready = 1'b0;
    host_write(27'h1C00064, 1'b1);
    checks++;
    if (host_cfg_busy !== 1'b1) begin errors++; $display("FAIL mid_busy: got %b required 1", host_cfg_busy); end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    exp_cfg_q.delete();
    checks++;
    if (cfg_tvalid !== 1'b0 || host_cfg_busy !== 1'b0 || active_cfg !== DEF_CFG) begin
      errors++;
      $display("FAIL mid_reset: got tvalid=%b busy=%b active=%h required 0 0 %h",
               cfg_tvalid, host_cfg_busy, active_cfg, DEF_CFG);
    end
  endtask

  initial begin
    test_reset();
    test_write_during_receive();
    test_write_while_busy();
    test_back_to_back();
    test_timeout();
    test_timeout_beat();
    test_timeout_gated();
    test_errors_irq();
    test_reset_mid_transaction();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
